// File: rtl/vmac_if.sv
// Command and result handshake bundle between the execute stage and the VMAC sequencer.
// The master side is the pipeline; the slave side is vmac_ctrl.
interface vmac_if #(
  parameter int LANES  = 4,
  parameter int ELEM_W = 32
);
  logic                      cmd_valid_i;
  logic                      cmd_ready_o;
  logic [1:0]                cmd_op_i;
  logic [2:0]                cmd_sel_i;
  logic [LANES*ELEM_W-1:0]   cmd_vs1_i;
  logic                      res_valid_o;
  logic                      res_ready_i;
  logic [LANES*ELEM_W-1:0]   res_data_o;

  modport master (
    output cmd_valid_i, cmd_op_i, cmd_sel_i, cmd_vs1_i, res_ready_i,
    input  cmd_ready_o, res_valid_o, res_data_o
  );

  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_sel_i, cmd_vs1_i, res_ready_i,
    output cmd_ready_o, res_valid_o, res_data_o
  );
endinterface

// File: rtl/vmac_ctrl.sv
// VMAC sequencer: weight buffer, accumulator vector and one shared multiplier
// stepped across lanes, with stall and result handshakes toward the pipeline.
module vmac_ctrl #(
  parameter int LANES  = 4,
  parameter int ELEM_W = 32,
  parameter int NSLOT  = 8
) (
  input  logic    clk,
  input  logic    rst,
  vmac_if.slave   bus,
  input  logic    flush_i,
  output logic    busy_o,
  output logic    done_o
);
  localparam int VREG_W = LANES * ELEM_W;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [1:0] OP_LW = 2'b01;
  localparam logic [1:0] OP_EN = 2'b10;
  localparam logic [1:0] OP_SW = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_r;
  logic [LANE_W-1:0]   lane_r;
  logic [2:0]          op_sel_r;
  logic [VREG_W-1:0]   op_vs1_r;
  logic [VREG_W-1:0]   acc_r;
  logic [VREG_W-1:0]   shadow_r;
  logic [VREG_W-1:0]   w_r [NSLOT];
  logic [VREG_W-1:0]   res_data_r;
  logic                res_valid_r;
  logic                done_r;

  logic                ready_s;
  logic                accept_s;
  logic                last_lane_s;
  logic [VREG_W-1:0]   w_sel_s;
  logic [ELEM_W-1:0]   mac_a_s;
  logic [ELEM_W-1:0]   mac_b_s;
  logic [ELEM_W-1:0]   sh_lane_s;
  logic [ELEM_W-1:0]   prod_lo_s;
  logic [ELEM_W-1:0]   sum_s;
  logic [VREG_W-1:0]   shadow_next_s;

  // A command raised during a flush is dropped even though ready is shown.
  assign ready_s     = (state_r == S_IDLE) & ~rst;
  assign accept_s    = bus.cmd_valid_i & ready_s & ~flush_i;
  assign last_lane_s = (lane_r == LANE_W'(LANES - 1));
  assign w_sel_s     = w_r[op_sel_r];

  // Select the current lane's operands and fold its product into the shadow copy.
  always_comb begin
    mac_a_s   = '0;
    mac_b_s   = '0;
    sh_lane_s = '0;
    for (int i = 0; i < LANES; i++) begin
      mac_a_s   = (lane_r == LANE_W'(i)) ? op_vs1_r[i*ELEM_W +: ELEM_W] : mac_a_s;
      mac_b_s   = (lane_r == LANE_W'(i)) ? w_sel_s[i*ELEM_W +: ELEM_W]  : mac_b_s;
      sh_lane_s = (lane_r == LANE_W'(i)) ? shadow_r[i*ELEM_W +: ELEM_W] : sh_lane_s;
    end
    prod_lo_s = mac_a_s * mac_b_s;
    sum_s     = sh_lane_s + prod_lo_s;
    shadow_next_s = shadow_r;
    for (int i = 0; i < LANES; i++) begin
      shadow_next_s[i*ELEM_W +: ELEM_W] = (lane_r == LANE_W'(i)) ? sum_s
                                                                 : shadow_r[i*ELEM_W +: ELEM_W];
    end
  end

  // Sequencer state, weight buffer, accumulator and registered result/done outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      lane_r      <= '0;
      op_sel_r    <= 3'd0;
      op_vs1_r    <= '0;
      acc_r       <= '0;
      shadow_r    <= '0;
      res_data_r  <= '0;
      res_valid_r <= 1'b0;
      done_r      <= 1'b0;
      for (int i = 0; i < NSLOT; i++) begin
        w_r[i] <= '0;
      end
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            case (bus.cmd_op_i)
              OP_LW: w_r[bus.cmd_sel_i] <= bus.cmd_vs1_i;
              OP_EN: begin
                op_vs1_r <= bus.cmd_vs1_i;
                op_sel_r <= bus.cmd_sel_i;
                shadow_r <= acc_r;
                lane_r   <= '0;
                state_r  <= S_MAC;
              end
              OP_SW: begin
                res_data_r  <= acc_r;
                acc_r       <= '0;
                res_valid_r <= 1'b1;
                state_r     <= S_RESP;
              end
              default: state_r <= S_IDLE;
            endcase
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_MAC: begin
          // Flush abandons the shadow copy; acc only changes on the final lane.
          if (flush_i) begin
            lane_r  <= '0;
            state_r <= S_IDLE;
          end else begin
            shadow_r <= shadow_next_s;
            lane_r   <= lane_r + LANE_W'(1);
            if (last_lane_s) begin
              acc_r   <= shadow_next_s;
              done_r  <= 1'b1;
              lane_r  <= '0;
              state_r <= S_IDLE;
            end else begin
              state_r <= S_MAC;
            end
          end
        end
        S_RESP: begin
          if (flush_i || bus.res_ready_i) begin
            res_valid_r <= 1'b0;
            state_r     <= S_IDLE;
          end else begin
            state_r <= S_RESP;
          end
        end
        default: begin
          res_valid_r <= 1'b0;
          lane_r      <= '0;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready_o = ready_s;
  assign bus.res_valid_o = res_valid_r;
  assign bus.res_data_o  = res_data_r;
  assign done_o          = done_r;
  // The accept-cycle term lets decode stall before the state register moves.
  assign busy_o = (state_r != S_IDLE) |
                  (bus.cmd_valid_i & ready_s & ((bus.cmd_op_i == OP_EN) | (bus.cmd_op_i == OP_SW)));

endmodule

// File: tb/tb_vmac_ctrl.sv
// Directed bench for vmac_ctrl: a command table with hand-computed results,
// plus reset, flush and writeback-backpressure sequences.
module tb_vmac_ctrl;
  localparam int LANES  = 4;
  localparam int ELEM_W = 32;
  localparam int VW     = LANES * ELEM_W;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_EN  = 2'b10;
  localparam logic [1:0] OP_SW  = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush_i = 1'b0;
  logic busy_o;
  logic done_o;

  vmac_if #(.LANES(LANES), .ELEM_W(ELEM_W)) bus ();

  vmac_ctrl #(.LANES(LANES), .ELEM_W(ELEM_W), .NSLOT(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .flush_i (flush_i),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]    op;
    logic [2:0]    sel;
    logic [VW-1:0] vs1;
    logic [VW-1:0] exp;
  } vec_t;

  vec_t tbl [16];

  function automatic logic [VW-1:0] vec4(input logic [31:0] a3, a2, a1, a0);
    return {a3, a2, a1, a0};
  endfunction

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Present one command while idle; returns 1 time unit after the accept edge.
  task automatic send(input logic [1:0] op, input logic [2:0] sel, input logic [VW-1:0] vs1);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_op_i    = op;
    bus.cmd_sel_i   = sel;
    bus.cmd_vs1_i   = vs1;
    #1;
    chk("ready_idle", VW'(bus.cmd_ready_o), VW'(1));
    chk("busy_accept", VW'(busy_o), VW'((op == OP_EN) || (op == OP_SW)));
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_op_i    = OP_NOP;
  endtask

  task automatic run_vec(input vec_t v);
    send(v.op, v.sel, v.vs1);
    case (v.op)
      OP_EN: begin
        chk("mac_busy0", VW'(busy_o), VW'(1));
        for (int k = 1; k <= LANES; k++) begin
          @(posedge clk); #1;
          if (k < LANES) begin
            chk("mac_done_early", VW'(done_o), VW'(0));
            chk("mac_busy", VW'(busy_o), VW'(1));
          end else begin
            chk("mac_done", VW'(done_o), VW'(1));
            chk("mac_end_busy", VW'(busy_o), VW'(0));
            chk("mac_end_ready", VW'(bus.cmd_ready_o), VW'(1));
          end
        end
        @(posedge clk); #1;
        chk("done_pulse", VW'(done_o), VW'(0));
      end
      OP_SW: begin
        chk("sw_valid", VW'(bus.res_valid_o), VW'(1));
        chk("sw_data", bus.res_data_o, v.exp);
        @(posedge clk); #1;
        chk("sw_release", VW'(bus.res_valid_o), VW'(0));
      end
      default: begin
        chk("idle_busy", VW'(busy_o), VW'(0));
        chk("idle_ready", VW'(bus.cmd_ready_o), VW'(1));
      end
    endcase
  endtask

  initial begin
    bus.cmd_valid_i = 1'b0;
    bus.cmd_op_i    = OP_NOP;
    bus.cmd_sel_i   = 3'd0;
    bus.cmd_vs1_i   = '0;
    bus.res_ready_i = 1'b1;

    tbl[0]  = '{OP_LW,  3'd3, vec4(32'd4, 32'd3, 32'd2, 32'd1), '0};
    tbl[1]  = '{OP_EN,  3'd3, vec4(32'd1, 32'd1, 32'd1, 32'd1), '0};
    tbl[2]  = '{OP_EN,  3'd3, vec4(32'd1, 32'd1, 32'd1, 32'd1), '0};
    tbl[3]  = '{OP_SW,  3'd0, '0, vec4(32'd8, 32'd6, 32'd4, 32'd2)};
    tbl[4]  = '{OP_LW,  3'd0, vec4(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF), '0};
    tbl[5]  = '{OP_EN,  3'd0, vec4(32'd2, 32'd2, 32'd2, 32'd2), '0};
    tbl[6]  = '{OP_EN,  3'd0, vec4(32'd2, 32'd2, 32'd2, 32'd2), '0};
    tbl[7]  = '{OP_SW,  3'd0, '0, vec4(32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFC)};
    tbl[8]  = '{OP_LW,  3'd7, vec4(32'd40, 32'd30, 32'd20, 32'd10), '0};
    tbl[9]  = '{OP_EN,  3'd7, vec4(32'd4, 32'd3, 32'd2, 32'd1), '0};
    tbl[10] = '{OP_SW,  3'd0, '0, vec4(32'd160, 32'd90, 32'd40, 32'd10)};
    tbl[11] = '{OP_LW,  3'd7, vec4(32'd7, 32'd7, 32'd7, 32'd7), '0};
    tbl[12] = '{OP_NOP, 3'd7, vec4(32'd9, 32'd9, 32'd9, 32'd9), '0};
    tbl[13] = '{OP_EN,  3'd7, vec4(32'd1, 32'd1, 32'd1, 32'd1), '0};
    tbl[14] = '{OP_SW,  3'd0, '0, vec4(32'd7, 32'd7, 32'd7, 32'd7)};
    tbl[15] = '{OP_SW,  3'd0, '0, '0};

    // Reset state while rst is held.
    #2;
    chk("rst_ready", VW'(bus.cmd_ready_o), VW'(0));
    chk("rst_busy", VW'(busy_o), VW'(0));
    chk("rst_done", VW'(done_o), VW'(0));
    chk("rst_valid", VW'(bus.res_valid_o), VW'(0));
    chk("rst_data", bus.res_data_o, '0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rel_ready", VW'(bus.cmd_ready_o), VW'(1));

    // Reset mid-EN, after lane 1 has been updated.
    send(OP_LW, 3'd2, vec4(32'd1, 32'd1, 32'd1, 32'd1));
    send(OP_EN, 3'd2, vec4(32'd3, 32'd3, 32'd3, 32'd3));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_ready", VW'(bus.cmd_ready_o), VW'(0));
    chk("midrst_busy", VW'(busy_o), VW'(0));
    chk("midrst_done", VW'(done_o), VW'(0));
    chk("midrst_valid", VW'(bus.res_valid_o), VW'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_no_done", VW'(done_o), VW'(0));
    run_vec('{OP_SW, 3'd0, '0, '0});

    // Command table.
    for (int i = 0; i < 16; i++) begin
      run_vec(tbl[i]);
    end

    // Flush at lane 2 of an EN with acc already {5,5,5,5}.
    run_vec('{OP_LW, 3'd1, vec4(32'd5, 32'd5, 32'd5, 32'd5), '0});
    run_vec('{OP_EN, 3'd1, vec4(32'd1, 32'd1, 32'd1, 32'd1), '0});
    send(OP_EN, 3'd1, vec4(32'd1, 32'd1, 32'd1, 32'd1));
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush_ready", VW'(bus.cmd_ready_o), VW'(1));
    chk("flush_busy", VW'(busy_o), VW'(0));
    for (int k = 0; k < LANES; k++) begin
      chk("flush_no_done", VW'(done_o), VW'(0));
      @(posedge clk); #1;
    end
    // An SW raised together with a flush in IDLE must be dropped.
    bus.cmd_valid_i = 1'b1;
    bus.cmd_op_i    = OP_SW;
    flush_i         = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_op_i    = OP_NOP;
    flush_i         = 1'b0;
    chk("flush_drop_cmd", VW'(bus.res_valid_o), VW'(0));
    run_vec('{OP_SW, 3'd0, '0, vec4(32'd5, 32'd5, 32'd5, 32'd5)});

    // Writeback backpressure with a second SW waiting.
    run_vec('{OP_LW, 3'd4, vec4(32'd4, 32'd3, 32'd2, 32'd1), '0});
    run_vec('{OP_EN, 3'd4, vec4(32'd1, 32'd1, 32'd1, 32'd1), '0});
    bus.res_ready_i = 1'b0;
    send(OP_SW, 3'd0, '0);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_op_i    = OP_SW;
    for (int k = 0; k < 3; k++) begin
      chk("stall_valid", VW'(bus.res_valid_o), VW'(1));
      chk("stall_data", bus.res_data_o, vec4(32'd4, 32'd3, 32'd2, 32'd1));
      chk("stall_ready", VW'(bus.cmd_ready_o), VW'(0));
      chk("stall_busy", VW'(busy_o), VW'(1));
      if (k < 2) begin
        @(posedge clk); #1;
      end
    end
    bus.res_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("hs_valid_drop", VW'(bus.res_valid_o), VW'(0));
    chk("hs_ready", VW'(bus.cmd_ready_o), VW'(1));
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_op_i    = OP_NOP;
    chk("sw2_valid", VW'(bus.res_valid_o), VW'(1));
    chk("sw2_data", bus.res_data_o, '0);
    @(posedge clk); #1;
    chk("sw2_release", VW'(bus.res_valid_o), VW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
